// File: rtl/hyper_cfg_seq_pkg.sv
// Shared types and helpers for the hyperbus boot-time configuration sequencer.
package hyper_cfg_seq_pkg;

   typedef enum logic [1:0] {
      ErrNone    = 2'd0,
      ErrBus     = 2'd1,
      ErrVerify  = 2'd2,
      ErrTimeout = 2'd3
   } err_code_e;

   typedef enum logic [2:0] {
      StIdle = 3'd0,
      StWr   = 3'd1,
      StRd   = 3'd2,
      StDone = 3'd3,
      StErr  = 3'd4
   } state_e;

   localparam int unsigned DefRegAw = 32;
   localparam int unsigned DefRegDw = 32;

   // Default regbus structs, matching the register_interface typedef layout.
   typedef struct packed {
      logic [DefRegAw-1:0]   addr;
      logic                  write;
      logic [DefRegDw-1:0]   wdata;
      logic [DefRegDw/8-1:0] wstrb;
      logic                  valid;
   } reg_req_t;

   typedef struct packed {
      logic [DefRegDw-1:0] rdata;
      logic                error;
      logic                ready;
   } reg_rsp_t;

   function automatic int unsigned clamp_entries(input int unsigned req_n, input int unsigned max_n);
      return (req_n > max_n) ? max_n : req_n;
   endfunction

endpackage

// File: rtl/hyper_cfg_seq_timeout.sv
// Saturating wait counter; expired_o flags the cycle whose wait would reach MaxCycles.
module hyper_cfg_seq_timeout #(
   parameter int unsigned MaxCycles = 256
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic clr_i,
   input  logic en_i,
   output logic expired_o
);

   localparam int unsigned CntW = (MaxCycles > 0) ? $clog2(MaxCycles + 1) : 1;

   logic [CntW-1:0] r_cnt;

   // Wait-cycle counter, saturating at the limit.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_cnt <= '0;
      end else if (clr_i) begin
         r_cnt <= '0;
      end else if (en_i && (r_cnt != CntW'(MaxCycles))) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   // MaxCycles of zero disables expiry altogether.
   assign expired_o = (MaxCycles != 32'd0) && en_i && ((32'(r_cnt) + 32'd1) >= MaxCycles);

endmodule

// File: rtl/hyper_cfg_sequencer.sv
// Walks a table of (addr, data, verify) entries as regbus writes with optional read-back compare.
module hyper_cfg_sequencer #(
   parameter int unsigned NumEntries    = 8,
   parameter int unsigned RegAw         = 32,
   parameter int unsigned RegDw         = 32,
   parameter int unsigned TimeoutCycles = 256,
   parameter type reg_req_t = hyper_cfg_seq_pkg::reg_req_t,
   parameter type reg_rsp_t = hyper_cfg_seq_pkg::reg_rsp_t,
   localparam int unsigned CntW = $clog2(NumEntries + 1),
   localparam int unsigned IdxW = (NumEntries > 1) ? $clog2(NumEntries) : 1
) (
   input  logic                                 clk_i,
   input  logic                                 rst_ni,
   input  logic                                 start_i,
   input  logic [CntW-1:0]                      num_entries_i,
   input  logic [NumEntries-1:0][RegAw-1:0]     tbl_addr_i,
   input  logic [NumEntries-1:0][RegDw-1:0]     tbl_data_i,
   input  logic [NumEntries-1:0]                tbl_verify_i,
   output reg_req_t                             reg_req_o,
   input  reg_rsp_t                             reg_rsp_i,
   output logic                                 busy_o,
   output logic                                 done_o,
   output logic                                 error_o,
   output logic [1:0]                           err_code_o,
   output logic [IdxW-1:0]                      err_idx_o
);

   import hyper_cfg_seq_pkg::*;

   state_e          r_state,    w_state_nxt;
   logic            r_gap,      w_gap_nxt;
   logic [IdxW-1:0] r_idx,      w_idx_nxt;
   logic [CntW-1:0] r_num,      w_num_nxt;
   err_code_e       r_err_code, w_err_code_nxt;
   logic [IdxW-1:0] r_err_idx,  w_err_idx_nxt;

   logic            w_busy, w_valid, w_hs, w_last, w_expired;
   logic [CntW-1:0] w_num_clamped;

   // Every transaction opens with one idle cycle (r_gap), so valid never runs back-to-back.
   assign w_busy        = (r_state == StWr) || (r_state == StRd);
   assign w_valid       = w_busy && !r_gap;
   assign w_hs          = w_valid && reg_rsp_i.ready;
   assign w_last        = (CntW'(r_idx) + CntW'(1)) == r_num;
   assign w_num_clamped = CntW'(clamp_entries(32'(num_entries_i), NumEntries));

   hyper_cfg_seq_timeout #(
      .MaxCycles (TimeoutCycles)
   ) u_timeout (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .clr_i     (!w_valid),
      .en_i      (w_valid && !reg_rsp_i.ready),
      .expired_o (w_expired)
   );

   // State and bookkeeping registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state    <= StIdle;
         r_gap      <= 1'b0;
         r_idx      <= '0;
         r_num      <= '0;
         r_err_code <= ErrNone;
         r_err_idx  <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_gap      <= w_gap_nxt;
         r_idx      <= w_idx_nxt;
         r_num      <= w_num_nxt;
         r_err_code <= w_err_code_nxt;
         r_err_idx  <= w_err_idx_nxt;
      end
   end

   // Next-state logic; a completed handshake always beats a simultaneous timeout.
   always_comb begin
      w_state_nxt    = r_state;
      w_gap_nxt      = 1'b0;
      w_idx_nxt      = r_idx;
      w_num_nxt      = r_num;
      w_err_code_nxt = r_err_code;
      w_err_idx_nxt  = r_err_idx;
      case (r_state)
         StIdle, StDone, StErr: begin
            if (start_i) begin
               w_err_code_nxt = ErrNone;
               w_err_idx_nxt  = '0;
               w_idx_nxt      = '0;
               w_num_nxt      = w_num_clamped;
               if (w_num_clamped == '0) begin
                  w_state_nxt = StDone;
               end else begin
                  w_state_nxt = StWr;
                  w_gap_nxt   = 1'b1;
               end
            end else begin
               w_state_nxt = r_state;
            end
         end
         StWr: begin
            if (r_gap) begin
               w_gap_nxt = 1'b0;
            end else if (w_hs) begin
               if (reg_rsp_i.error) begin
                  w_state_nxt    = StErr;
                  w_err_code_nxt = ErrBus;
                  w_err_idx_nxt  = r_idx;
               end else if (tbl_verify_i[r_idx]) begin
                  w_state_nxt = StRd;
                  w_gap_nxt   = 1'b1;
               end else if (w_last) begin
                  w_state_nxt = StDone;
               end else begin
                  w_idx_nxt   = r_idx + 1'b1;
                  w_state_nxt = StWr;
                  w_gap_nxt   = 1'b1;
               end
            end else if (w_expired) begin
               w_state_nxt    = StErr;
               w_err_code_nxt = ErrTimeout;
               w_err_idx_nxt  = r_idx;
            end else begin
               w_state_nxt = StWr;
            end
         end
         StRd: begin
            if (r_gap) begin
               w_gap_nxt = 1'b0;
            end else if (w_hs) begin
               if (reg_rsp_i.error) begin
                  w_state_nxt    = StErr;
                  w_err_code_nxt = ErrBus;
                  w_err_idx_nxt  = r_idx;
               end else if (reg_rsp_i.rdata != tbl_data_i[r_idx]) begin
                  w_state_nxt    = StErr;
                  w_err_code_nxt = ErrVerify;
                  w_err_idx_nxt  = r_idx;
               end else if (w_last) begin
                  w_state_nxt = StDone;
               end else begin
                  w_idx_nxt   = r_idx + 1'b1;
                  w_state_nxt = StWr;
                  w_gap_nxt   = 1'b1;
               end
            end else if (w_expired) begin
               w_state_nxt    = StErr;
               w_err_code_nxt = ErrTimeout;
               w_err_idx_nxt  = r_idx;
            end else begin
               w_state_nxt = StRd;
            end
         end
         default: begin
            w_state_nxt = StIdle;
         end
      endcase
   end

   // Request fields decode from registered state, so they hold steady until the handshake.
   always_comb begin
      reg_req_o       = '0;
      reg_req_o.wstrb = '1;
      if (w_busy) begin
         reg_req_o.addr  = tbl_addr_i[r_idx];
         reg_req_o.wdata = tbl_data_i[r_idx];
         reg_req_o.write = (r_state == StWr);
         reg_req_o.valid = w_valid;
      end else begin
         reg_req_o.valid = 1'b0;
      end
   end

   assign busy_o     = w_busy;
   assign done_o     = (r_state == StDone);
   assign error_o    = (r_state == StErr);
   assign err_code_o = r_err_code;
   assign err_idx_o  = r_err_idx;

endmodule

// File: tb/tb_hyper_cfg_sequencer.sv
// Scoreboard bench for hyper_cfg_sequencer: expected bus accesses queued per run, checked at handshake.
module tb_hyper_cfg_sequencer;

   import hyper_cfg_seq_pkg::*;

   localparam int unsigned NE = 8;
   localparam int unsigned TO = 16;

   logic                   clk_i = 1'b0;
   logic                   rst_ni = 1'b0;
   logic                   start_i = 1'b0;
   logic [3:0]             num_entries_i = 4'd0;
   logic [NE-1:0][31:0]    tbl_addr;
   logic [NE-1:0][31:0]    tbl_data;
   logic [NE-1:0]          tbl_verify;
   reg_req_t               req;
   reg_rsp_t               rsp;
   logic                   busy, done, error;
   logic [1:0]             err_code;
   logic [2:0]             err_idx;

   int n_tests = 0;
   int n_fail  = 0;

   logic        rs_ready    = 1'b1;
   logic        rs_bad_rd   = 1'b0;
   logic        rs_err_en   = 1'b0;
   logic [31:0] rs_err_addr = 32'd0;
   logic [31:0] mem [16];

   typedef struct packed {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] data;
   } exp_t;
   exp_t sb_q[$];
   exp_t m_e;

   always #5 clk_i = ~clk_i;

   hyper_cfg_sequencer #(
      .NumEntries    (NE),
      .RegAw         (32),
      .RegDw         (32),
      .TimeoutCycles (TO)
   ) dut (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .start_i       (start_i),
      .num_entries_i (num_entries_i),
      .tbl_addr_i    (tbl_addr),
      .tbl_data_i    (tbl_data),
      .tbl_verify_i  (tbl_verify),
      .reg_req_o     (req),
      .reg_rsp_i     (rsp),
      .busy_o        (busy),
      .done_o        (done),
      .error_o       (error),
      .err_code_o    (err_code),
      .err_idx_o     (err_idx)
   );

   always_comb begin
      rsp       = '0;
      rsp.ready = rs_ready;
      rsp.error = rs_err_en && req.valid && req.write && (req.addr == rs_err_addr);
      rsp.rdata = rs_bad_rd ? 32'hDEAD_BEEF : mem[req.addr[5:2]];
   end

   always @(posedge clk_i) begin
      if (req.valid && rsp.ready && req.write) mem[req.addr[5:2]] <= req.wdata;
   end

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic push(input logic wr, input int i);
      exp_t e;
      e.wr   = wr;
      e.addr = tbl_addr[i];
      e.data = tbl_data[i];
      sb_q.push_back(e);
   endtask

   // Bus monitor: gap after every handshake, stable request while stalled, scoreboard pop.
   logic     m_prev_hs   = 1'b0;
   logic     m_prev_pend = 1'b0;
   reg_req_t m_prev_req;
   always @(negedge clk_i) begin
      if (!rst_ni) begin
         m_prev_hs   = 1'b0;
         m_prev_pend = 1'b0;
      end else begin
         if (m_prev_hs) check("gap", 64'(req.valid), 64'd0);
         if (m_prev_pend && req.valid) begin
            check("stable_addr", 64'(req.addr), 64'(m_prev_req.addr));
            check("stable_wdata", 64'(req.wdata), 64'(m_prev_req.wdata));
            check("stable_wr", 64'(req.write), 64'(m_prev_req.write));
         end
         if (req.valid && rsp.ready) begin
            check("sb_expected", 64'(sb_q.size() != 0), 64'd1);
            if (sb_q.size() != 0) begin
               m_e = sb_q.pop_front();
               check("bus_wr", 64'(req.write), 64'(m_e.wr));
               check("bus_addr", 64'(req.addr), 64'(m_e.addr));
               check("bus_wstrb", 64'(req.wstrb), 64'hF);
               if (m_e.wr) check("bus_wdata", 64'(req.wdata), 64'(m_e.data));
            end
         end
         m_prev_hs   = req.valid && rsp.ready;
         m_prev_pend = req.valid && !rsp.ready;
         m_prev_req  = req;
      end
   end

   // Pulses start, then counts cycles until done/error; poke re-pulses start mid-run.
   task automatic run_seq(input string tag, input int n, input int poke,
                          output int cyc, output int busy_c, output int valid_c);
      logic ended;
      @(negedge clk_i);
      num_entries_i = 4'(n);
      start_i = 1'b1;
      cyc = 0; busy_c = 0; valid_c = 0; ended = 1'b0;
      while (!ended && cyc < 300) begin
         @(negedge clk_i);
         cyc++;
         start_i = (cyc == poke);
         if (busy) busy_c++;
         if (req.valid) valid_c++;
         if (done || error) ended = 1'b1;
      end
      start_i = 1'b0;
      check({tag, "_end"}, 64'(ended), 64'd1);
   endtask

   task automatic check_end(input string tag, input logic e_done, input logic e_err,
                            input logic [1:0] e_code, input logic [2:0] e_idx);
      check({tag, "_done"}, 64'(done), 64'(e_done));
      check({tag, "_error"}, 64'(error), 64'(e_err));
      check({tag, "_code"}, 64'(err_code), 64'(e_code));
      check({tag, "_idx"}, 64'(err_idx), 64'(e_idx));
      check({tag, "_busy"}, 64'(busy), 64'd0);
      check({tag, "_sb_empty"}, 64'(sb_q.size()), 64'd0);
   endtask

   initial begin
      int cyc, bc, vc;
      for (int i = 0; i < int'(NE); i++) begin
         tbl_addr[i] = 32'(i * 4);
         tbl_data[i] = 32'h0000_8F1E + 32'(i);
      end
      tbl_verify = '0;

      repeat (3) @(negedge clk_i);
      check("rst_valid", 64'(req.valid), 64'd0);
      check("rst_outs", 64'({busy, done, error, err_code, err_idx}), 64'd0);
      check("rst_wstrb", 64'(req.wstrb), 64'hF);
      check("rst_addr", 64'(req.addr), 64'd0);
      @(negedge clk_i);
      rst_ni = 1'b1;

      // Three plain writes, with a start pulse mid-run that must be ignored.
      for (int i = 0; i < 3; i++) push(1'b1, i);
      run_seq("t1", 3, 3, cyc, bc, vc);
      check("t1_cycles", 64'(cyc), 64'd7);
      check("t1_busy_cycles", 64'(bc), 64'd6);
      check("t1_valid_cycles", 64'(vc), 64'd3);
      check_end("t1", 1'b1, 1'b0, 2'd0, 3'd0);

      // Entry 1 verified, good read-back.
      tbl_verify[1] = 1'b1;
      push(1'b1, 0); push(1'b1, 1); push(1'b0, 1); push(1'b1, 2);
      run_seq("t2", 3, 0, cyc, bc, vc);
      check("t2_cycles", 64'(cyc), 64'd9);
      check("t2_busy_cycles", 64'(bc), 64'd8);
      check_end("t2", 1'b1, 1'b0, 2'd0, 3'd0);

      // Verify mismatch on entry 1; entry 2 must never be touched.
      rs_bad_rd = 1'b1;
      push(1'b1, 0); push(1'b1, 1); push(1'b0, 1);
      run_seq("t3", 3, 0, cyc, bc, vc);
      check("t3_cycles", 64'(cyc), 64'd7);
      check_end("t3", 1'b0, 1'b1, 2'd2, 3'd1);
      rs_bad_rd  = 1'b0;
      tbl_verify = '0;

      // Stalled bus: valid holds for exactly TO cycles, then timeout.
      rs_ready = 1'b0;
      run_seq("t4", 3, 0, cyc, bc, vc);
      check("t4_valid_cycles", 64'(vc), 64'(TO));
      check("t4_cycles", 64'(cyc), 64'(TO + 2));
      check_end("t4", 1'b0, 1'b1, 2'd3, 3'd0);
      rs_ready = 1'b1;

      // Bus error on entry 2 write, then a clean restart.
      rs_err_en   = 1'b1;
      rs_err_addr = 32'h8;
      for (int i = 0; i < 3; i++) push(1'b1, i);
      run_seq("t5", 3, 0, cyc, bc, vc);
      check("t5_cycles", 64'(cyc), 64'd7);
      check_end("t5", 1'b0, 1'b1, 2'd1, 3'd2);
      rs_err_en = 1'b0;
      for (int i = 0; i < 3; i++) push(1'b1, i);
      run_seq("t5r", 3, 0, cyc, bc, vc);
      check("t5r_cycles", 64'(cyc), 64'd7);
      check_end("t5r", 1'b1, 1'b0, 2'd0, 3'd0);

      // Oversized count clamps to the full table.
      for (int i = 0; i < int'(NE); i++) push(1'b1, i);
      run_seq("t6", 15, 0, cyc, bc, vc);
      check("t6_cycles", 64'(cyc), 64'(2 * NE + 1));
      check_end("t6", 1'b1, 1'b0, 2'd0, 3'd0);

      // Reset mid-write with a stalled bus.
      rs_ready = 1'b0;
      @(negedge clk_i);
      num_entries_i = 4'd3;
      start_i = 1'b1;
      @(negedge clk_i);
      start_i = 1'b0;
      @(negedge clk_i);
      check("t7_valid_pre", 64'(req.valid), 64'd1);
      #2 rst_ni = 1'b0;
      #1;
      check("t7_valid_rst", 64'(req.valid), 64'd0);
      check("t7_outs_rst", 64'({busy, done, error, err_code, err_idx}), 64'd0);
      check("t7_addr_rst", 64'({req.addr, req.write}), 64'd0);
      check("t7_wstrb_rst", 64'(req.wstrb), 64'hF);
      repeat (2) @(negedge clk_i);
      rst_ni   = 1'b1;
      rs_ready = 1'b1;

      // Zero entries: done the cycle after start, no bus traffic.
      run_seq("t8", 0, 0, cyc, bc, vc);
      check("t8_cycles", 64'(cyc), 64'd1);
      check("t8_valid_cycles", 64'(vc), 64'd0);
      check("t8_busy_cycles", 64'(bc), 64'd0);
      check_end("t8", 1'b1, 1'b0, 2'd0, 3'd0);

      repeat (3) @(negedge clk_i);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
